adder_arbiter: RTL

Round-robin arbiter and sequencer that shares one registered 4-bit adder among up to NREQ requesters. Each requester presents an operand pair through a valid/ready handshake. The block grants one requester, drives the adder's operand/valid inputs, captures the registered sum, and returns it with the requester's index through a valid/ready response port. It sits between the requesting datapath units and the single adder instance.

---
 rtl/adder_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin arbiter that time-shares one registered adder among
// NREQ requesters. One transaction at a time: grant, issue, wait, respond.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   req_valid/req_ready per-requester handshake (req_ready one-hot, IDLE only)
//   req_a/req_b         packed operands, requester i at [i*W +: W]
//   add_a/add_b         registered operands to the shared adder
//   add_valid           one-cycle strobe to the adder
//   add_c               adder result, valid the cycle after add_valid
//   rsp_valid/rsp_ready response handshake
//   rsp_data/rsp_id     result and index of the requester that produced it
//   busy                high whenever the sequencer is not idle
module adder_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = 4,
  parameter int unsigned CW   = 7,
  parameter int unsigned IW   = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [W-1:0]      add_a,
  output logic [W-1:0]      add_b,
  output logic              add_valid,
  input  logic [CW-1:0]     add_c,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [CW-1:0]     rsp_data,
  output logic [IW-1:0]     rsp_id,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   last_grant_q;
  logic [W-1:0]    add_a_q, add_b_q;
  logic [CW-1:0]   rsp_data_q;
  logic [IW-1:0]   rsp_id_q;

  logic            gnt_found;
  logic [IW-1:0]   gnt_idx;
  logic [IW-1:0]   cand;
  logic [W-1:0]    gnt_a, gnt_b;
  logic            grant;

  // Rotating priority: search from last_grant+1 upward; IW-bit wrap gives mod NREQ
  // because NREQ is a power of two.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = last_grant_q;
    cand      = last_grant_q;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = last_grant_q + IW'(k);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  always_comb begin
    gnt_a = '0;
    gnt_b = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (IW'(i) == gnt_idx) begin
        gnt_a = req_a[i*W +: W];
        gnt_b = req_b[i*W +: W];
      end
    end
  end

  assign grant = (state_q == StIdle) && gnt_found;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (gnt_found) state_d = StIssue;
      StIssue: state_d = StWait;
      StWait:  state_d = StResp;
      StResp:  if (rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output decode; req_ready is the only combinational path from inputs.
  // Gated by rst so it reads zero while reset is asserted.
  always_comb begin
    req_ready = '0;
    if (grant && !rst) req_ready[gnt_idx] = 1'b1;
    add_valid = (state_q == StIssue);
    rsp_valid = (state_q == StResp);
    busy      = (state_q != StIdle);
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= IW'(NREQ - 1);
      add_a_q      <= '0;
      add_b_q      <= '0;
      rsp_id_q     <= '0;
      rsp_data_q   <= '0;
    end else begin
      if (grant) begin
        add_a_q      <= gnt_a;
        add_b_q      <= gnt_b;
        rsp_id_q     <= gnt_idx;
        last_grant_q <= gnt_idx;
      end
      if (state_q == StWait) begin
        rsp_data_q <= add_c;
      end
    end
  end

  assign add_a    = add_a_q;
  assign add_b    = add_b_q;
  assign rsp_data = rsp_data_q;
  assign rsp_id   = rsp_id_q;

endmodule
